uart_rx_fsm: RTL

Sequencing controller for the UART receiver datapath. It detects a falling edge on the serial line and runs the frame: start, DATA_W data bits, optional parity, stop. Its enables drive the bit sampler, start-bit checker, deserializer, parity checker and stop checker. It owns the oversampling edge counter and bit counter, and issues a one-cycle data_valid for each error-free frame.

---
 rtl/uart_rx_fsm.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive sequencer driving sampler/checker enables, edge and bit counters.
// Optional UART_RX_ERR_STATUS_EN adds par_err_flag/stp_err_flag outputs.
module uart_rx_fsm #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  uart_rx_fsm_clk,
    input  logic                  uart_rx_fsm_rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  dat_samp_en,
    output logic                  strt_chk_en,
    output logic                  deser_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
`ifdef UART_RX_ERR_STATUS_EN
    output logic                  par_err_flag,
    output logic                  stp_err_flag,
`endif
    output logic                  data_valid
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   edge_q, edge_d, p_q, p_d, chk_d, fin, stop_end;
    logic [3:0]              bit_q, bit_d;
    logic                    par_en_q, par_en_d, par_flag_q, par_flag_d;
    logic                    strt_q, deser_q, parc_q, stpc_q, samp_q;
    logic                    wrap, stop_done;

    assign fin       = p_q - PRESCALE_W'(1);
    assign stop_end  = (p_q >> 1) + PRESCALE_W'(3);
    assign chk_d     = (p_d >> 1) + PRESCALE_W'(2);
    assign wrap      = edge_q == fin;
    assign stop_done = state_q == STOP && edge_q == stop_end;

    always_comb begin
        state_d    = state_q;
        edge_d     = wrap ? '0 : edge_q + PRESCALE_W'(1);
        bit_d      = wrap ? bit_q + 4'd1 : bit_q;
        p_d        = p_q;
        par_en_d   = par_en_q;
        par_flag_d = par_flag_q;
        case (state_q)
            IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                if (!rx_in) begin
                    state_d    = START;
                    p_d        = prescale < PRESCALE_W'(8) ? PRESCALE_W'(8) : prescale;
                    par_en_d   = par_en;
                    par_flag_d = 1'b0;
                end
            end
            START: begin
                if (wrap && strt_glitch) begin
                    state_d = IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                end else if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: if (wrap && bit_q == 4'(DATA_W)) state_d = par_en_q ? PARITY : STOP;
            PARITY: begin
                if (wrap) begin
                    par_flag_d = par_err;
                    state_d    = STOP;
                end
            end
            STOP: begin
                // Leave mid-stop-bit so a following start edge is not missed
                if (stop_done) begin
                    state_d = IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge uart_rx_fsm_clk) begin
        if (uart_rx_fsm_rst) begin
            state_q    <= IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            p_q        <= '0;
            par_en_q   <= 1'b0;
            par_flag_q <= 1'b0;
            samp_q     <= 1'b0;
            strt_q     <= 1'b0;
            deser_q    <= 1'b0;
            parc_q     <= 1'b0;
            stpc_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            p_q        <= p_d;
            par_en_q   <= par_en_d;
            par_flag_q <= par_flag_d;
            samp_q     <= state_d != IDLE;
            strt_q     <= state_d == START && edge_d == chk_d;
            deser_q    <= state_d == DATA && edge_d == chk_d;
            parc_q     <= state_d == PARITY && edge_d == chk_d;
            stpc_q     <= state_d == STOP && edge_d == chk_d;
        end
    end

    assign edge_cnt    = edge_q;
    assign bit_cnt     = bit_q;
    assign dat_samp_en = samp_q;
    assign strt_chk_en = strt_q;
    assign deser_en    = deser_q;
    assign par_chk_en  = parc_q;
    assign stp_chk_en  = stpc_q;
    // stp_err is the registered stop-check result, valid one cycle after stp_chk_en
    assign data_valid  = stop_done && !stp_err && !par_flag_q;
`ifdef UART_RX_ERR_STATUS_EN
    assign par_err_flag = stop_done && par_flag_q;
    assign stp_err_flag = stop_done && stp_err;
`endif
endmodule
